sram_port_sched: RTL and testbench

//  Sequences one asynchronous SRAM port (BaseRAM) shared by the IFU and the LSU.

---
 rtl/sram_port_sched_if.sv | 42 ++++
 rtl/sram_port_sched.sv | 176 +++++++++++++++++
 tb/tb_sram_port_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_sched_if.sv
// rtl/sram_port_sched_if.sv - IFU/LSU request ports and BaseRAM pins of the SRAM port scheduler
interface sram_port_sched_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              ifu_req_i;
    logic [ADDR_W-1:0] ifu_addr_i;
    logic              ifu_resp_o;
    logic [DATA_W-1:0] ifu_rdata_o;

    logic              lsu_req_i;
    logic              lsu_we_n_i;
    logic [3:0]        lsu_be_n_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic              lsu_resp_o;
    logic [DATA_W-1:0] lsu_rdata_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;
    logic [3:0]        ram_be_n_o;
    logic              ram_ce_n_o;
    logic              ram_oe_n_o;
    logic              ram_we_n_o;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        input  lsu_req_i, lsu_we_n_i, lsu_be_n_i, lsu_addr_i, lsu_wdata_i,
        input  ram_rdata_i,
        output ifu_resp_o, ifu_rdata_o, lsu_resp_o, lsu_rdata_o,
        output ram_addr_o, ram_wdata_o, ram_be_n_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        output lsu_req_i, lsu_we_n_i, lsu_be_n_i, lsu_addr_i, lsu_wdata_i,
        output ram_rdata_i,
        input  ifu_resp_o, ifu_rdata_o, lsu_resp_o, lsu_rdata_o,
        input  ram_addr_o, ram_wdata_o, ram_be_n_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );
endinterface

// File: rtl/sram_port_sched.sv
// rtl/sram_port_sched.sv - IFU/LSU arbiter and ce_n/oe_n/we_n sequencer for one asynchronous SRAM port
module sram_port_sched #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 2,
    parameter int LSU_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_port_sched_if.slave   bus
);
    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int STK_W   = (LSU_STREAK > 1) ? $clog2(LSU_STREAK + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WR_HOLD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STK_W-1:0]  streak_q, streak_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ifu_resp_q, ifu_resp_d;
    logic              lsu_resp_q, lsu_resp_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              grant_lsu;
    logic              grant_ifu;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_n_d      = be_n_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        // LSU wins unless the IFU is waiting and the LSU has used up its streak.
        grant_lsu   = bus.lsu_req_i && (!bus.ifu_req_i || (streak_q < STK_W'(LSU_STREAK)));
        grant_ifu   = !grant_lsu && bus.ifu_req_i;

        case (state_q)
            S_IDLE: begin
                if (!bus.ifu_req_i) begin
                    streak_d = '0;
                end
                if (grant_lsu) begin
                    owner_lsu_d = 1'b1;
                    if (bus.ifu_req_i && (streak_q != STK_W'(LSU_STREAK))) begin
                        streak_d = streak_q + STK_W'(1);
                    end
                    addr_d  = bus.lsu_addr_i;
                    wdata_d = bus.lsu_wdata_i;
                    be_n_d  = bus.lsu_be_n_i;
                    ce_n_d  = 1'b0;
                    if (bus.lsu_we_n_i) begin
                        state_d = S_RD;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(RD_WAIT);
                    end else begin
                        state_d = S_WR;
                        we_n_d  = 1'b0;
                        // WR occupies WR_WAIT cycles: count down from WR_WAIT-1 to 0.
                        cnt_d   = CNT_W'(WR_WAIT - 1);
                    end
                end else if (grant_ifu) begin
                    owner_lsu_d = 1'b0;
                    streak_d    = '0;
                    addr_d      = bus.ifu_addr_i;
                    be_n_d      = 4'h0;
                    ce_n_d      = 1'b0;
                    oe_n_d      = 1'b0;
                    state_d     = S_RD;
                    cnt_d       = CNT_W'(RD_WAIT);
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (owner_lsu_q) begin
                        lsu_resp_d  = 1'b1;
                        lsu_rdata_d = bus.ram_rdata_i;
                    end else begin
                        ifu_resp_d  = 1'b1;
                        ifu_rdata_d = bus.ram_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                // Address and data stay driven one cycle past the we_n rising edge.
                state_d    = S_DONE;
                ce_n_d     = 1'b1;
                lsu_resp_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= 4'hF;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_n_q      <= be_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign bus.ifu_resp_o  = ifu_resp_q;
    assign bus.ifu_rdata_o = ifu_rdata_q;
    assign bus.lsu_resp_o  = lsu_resp_q;
    assign bus.lsu_rdata_o = lsu_rdata_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_wdata_o = wdata_q;
    assign bus.ram_be_n_o  = be_n_q;
    assign bus.ram_ce_n_o  = ce_n_q;
    assign bus.ram_oe_n_o  = oe_n_q;
    assign bus.ram_we_n_o  = we_n_q;
endmodule

// File: tb/tb_sram_port_sched.sv
// tb/tb_sram_port_sched.sv - self-checking bench for sram_port_sched
module tb_sram_port_sched;
    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 32;
    localparam int RD_WAIT    = 1;
    localparam int WR_WAIT    = 2;
    localparam int LSU_STREAK = 4;
    localparam int RD_LAT     = RD_WAIT + 2;
    localparam int WR_LAT     = WR_WAIT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_sched #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT), .LSU_STREAK(LSU_STREAK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [31:0] mem_val(input logic [7:0] a);
        if (a == 8'h10) return 32'h12345678;
        return {8'hA5, a, ~a, 8'h5A};
    endfunction

    // Data is only driven while the SRAM is selected for reading.
    assign bus.ram_rdata_i = (!bus.ram_ce_n_o && !bus.ram_oe_n_o) ?
                             mem_val(bus.ram_addr_o[7:0]) : 32'hDEADBEEF;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        lsu;
        logic        is_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mdl_ifu_rdata = '0;
    logic [31:0] mdl_lsu_rdata = '0;
    int          last_lsu_resp = 0;
    int          lsu_gap = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_resp", 64'(bus.ifu_resp_o & bus.lsu_resp_o), 64'd0);
            chk("oe_we_excl", 64'(!bus.ram_oe_n_o && !bus.ram_we_n_o), 64'd0);
            if (bus.ifu_resp_o || bus.lsu_resp_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_owner", 64'(bus.lsu_resp_o), 64'(mon_e.lsu));
                    if (mon_e.is_rd) begin
                        if (mon_e.lsu) mdl_lsu_rdata = mon_e.rdata;
                        else           mdl_ifu_rdata = mon_e.rdata;
                    end
                end
                chk("ifu_rdata", 64'(bus.ifu_rdata_o), 64'(mdl_ifu_rdata));
                chk("lsu_rdata", 64'(bus.lsu_rdata_o), 64'(mdl_lsu_rdata));
                if (bus.lsu_resp_o) begin
                    lsu_gap = cyc - last_lsu_resp;
                    last_lsu_resp = cyc;
                end
            end
        end
    end

    typedef struct {
        logic        lsu;
        logic        we_n;
        logic [3:0]  be_n;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic drop_reqs();
        bus.ifu_req_i = 1'b0;
        bus.lsu_req_i = 1'b0;
    endtask

    task automatic reset_check(input string name);
        chk(name, {bus.ram_ce_n_o, bus.ram_oe_n_o, bus.ram_we_n_o, bus.ram_be_n_o,
                   bus.ram_addr_o, bus.ram_wdata_o, bus.ifu_resp_o, bus.lsu_resp_o},
            {3'b111, 4'hF, 20'h0, 32'h0, 2'b00});
        chk({name, "_rdata"}, {bus.ifu_rdata_o, bus.lsu_rdata_o}, 64'd0);
    endtask

    // One access from a single requester, checking the SRAM pins every cycle.
    task automatic run_access(input vec_t v);
        logic       is_rd;
        logic       done;
        logic       rsp_self;
        logic       rsp_other;
        logic [2:0] exp_strb;
        exp_t       e;
        is_rd = v.lsu ? v.we_n : 1'b1;
        @(negedge clk);
        if (v.lsu) begin
            bus.lsu_req_i   = 1'b1;
            bus.lsu_we_n_i  = v.we_n;
            bus.lsu_be_n_i  = v.be_n;
            bus.lsu_addr_i  = v.addr;
            bus.lsu_wdata_i = v.wdata;
        end else begin
            bus.ifu_req_i  = 1'b1;
            bus.ifu_addr_i = v.addr;
        end
        e.lsu = v.lsu;
        e.is_rd = is_rd;
        e.rdata = v.rdata;
        sb_q.push_back(e);
        done = 1'b0;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            if (k >= v.lat)                      exp_strb = 3'b111;
            else if (is_rd)                      exp_strb = 3'b001;
            else if (k <= WR_WAIT)               exp_strb = 3'b010;
            else                                 exp_strb = 3'b011;
            rsp_self  = v.lsu ? bus.lsu_resp_o : bus.ifu_resp_o;
            rsp_other = v.lsu ? bus.ifu_resp_o : bus.lsu_resp_o;
            chk("pins", {bus.ram_ce_n_o, bus.ram_oe_n_o, bus.ram_we_n_o, rsp_self, rsp_other,
                         bus.ram_be_n_o, bus.ram_addr_o},
                {exp_strb, (k == v.lat), 1'b0, (v.lsu ? v.be_n : 4'h0), v.addr});
            if (!is_rd) chk("wdata_held", 64'(bus.ram_wdata_o), 64'(v.wdata));
            if (rsp_self) begin
                chk("latency", 64'(k), 64'(v.lat));
                done = 1'b1;
            end
        end
        if (!done) chk("resp_timeout", 64'd0, 64'd1);
        drop_reqs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t e;
        vecs[0] = '{1'b0, 1'b1, 4'h0,    20'h00010, 32'h0,        RD_LAT, 32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 4'b1100, 20'h00020, 32'hCAFEF00D, WR_LAT, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 4'h0,    20'h00011, 32'h0,        RD_LAT, mem_val(8'h11)};
        vecs[3] = '{1'b0, 1'b1, 4'h0,    20'hFFFFF, 32'h0,        RD_LAT, mem_val(8'hFF)};
        vecs[4] = '{1'b1, 1'b0, 4'h0,    20'h00000, 32'hFFFFFFFF, WR_LAT, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 4'b1010, 20'h00055, 32'h0,        RD_LAT, mem_val(8'h55)};

        bus.ifu_req_i   = 1'b0;
        bus.ifu_addr_i  = '0;
        bus.lsu_req_i   = 1'b0;
        bus.lsu_we_n_i  = 1'b1;
        bus.lsu_be_n_i  = 4'hF;
        bus.lsu_addr_i  = '0;
        bus.lsu_wdata_i = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_check("reset_state");
        rst_n = 1'b1;

        // Single-requester accesses; entries 2 and 3 also show each rdata_o only moving on its own resp.
        for (int i = 0; i < 6; i++) run_access(vecs[i]);

        // Back-to-back LSU reads with the IFU idle: one resp every RD_LAT+1 cycles.
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 1'b1, 4'h0, 20'(32'h60 + i), 32'h0, RD_LAT, mem_val(8'(8'h60 + i))};
            run_access(v);
            #1;
            if (i > 0) chk("lsu_b2b_gap", 64'(lsu_gap), 64'(RD_LAT + 1));
        end

        // Both requesters hold req: the scoreboard order encodes L,L,L,L,I,L,L,L,L,I.
        @(negedge clk);
        bus.ifu_req_i  = 1'b1;
        bus.ifu_addr_i = 20'h00030;
        bus.lsu_req_i  = 1'b1;
        bus.lsu_we_n_i = 1'b1;
        bus.lsu_be_n_i = 4'h0;
        bus.lsu_addr_i = 20'h00040;
        for (int i = 0; i < 10; i++) begin
            e.lsu   = ((i % 5) != 4);
            e.is_rd = 1'b1;
            e.rdata = e.lsu ? mem_val(8'h40) : mem_val(8'h30);
            sb_q.push_back(e);
        end
        for (int i = 0; i < 80 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("arb_pending", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        drop_reqs();

        // Reset while a write is in the WR state: strobes release at once and no resp follows.
        @(negedge clk);
        bus.lsu_req_i   = 1'b1;
        bus.lsu_we_n_i  = 1'b0;
        bus.lsu_be_n_i  = 4'h0;
        bus.lsu_addr_i  = 20'h00033;
        bus.lsu_wdata_i = 32'h11112222;
        @(negedge clk);
        chk("wr_in_progress", {bus.ram_ce_n_o, bus.ram_oe_n_o, bus.ram_we_n_o}, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("mid_wr_reset");
        mdl_ifu_rdata = '0;
        mdl_lsu_rdata = '0;
        drop_reqs();
        repeat (2) @(negedge clk);
        reset_check("reset_held");
        rst_n = 1'b1;
        v = '{1'b1, 1'b1, 4'b0110, 20'h00044, 32'h0, RD_LAT, mem_val(8'h44)};
        run_access(v);
        repeat (3) @(negedge clk);
        chk("idle_after", {bus.ram_ce_n_o, bus.ram_oe_n_o, bus.ram_we_n_o}, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
